dtw_job_sched: RTL and testbench
================================

# dtw_job_sched

Job scheduler that sequences one `dtw_core` instance through a complete alignment job:
- resets the core;
- optionally loads a reference;
- runs a programmed number of query passes;
- reports completion or timeout.

It sits between the AXI-Lite register file and the core. It replaces direct software toggling of the core's reset, run/stop and mode bits, and adds a watchdog and a completed-query counter.

## Interface
Parameters:
- `RST_CYCLES`, 4: cycles `core_rst` is held high at job start (≥1).
- `TIMEOUT_W`, 24: watchdog counter width.
- `CNT_W`, 16: query-count width.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle job request. Accepted only in IDLE, DONE or ERROR.
- `abort` in 1: stop the job and return to IDLE.
- `cfg_load_ref` in 1: job includes a reference-load phase.
- `cfg_ref_len` in 32: reference length, latched at `start`.
- `cfg_num_q` in CNT_W: number of queries, latched at `start`. A value of 0 means load-only.
- `cfg_timeout` in TIMEOUT_W: watchdog limit, latched at `start`. A value of 0 disables the watchdog.
- `core_rst` out 1: drives core `rst`.
- `core_rs` out 1: drives core `rs`.
- `core_mode` out 1: drives core `op_mode`. 1 = reference load, 0 = query.
- `core_ref_len` out 32: drives core `ref_len`.
- `core_busy` in 1: core `busy`.
- `core_load_done` in 1: core `load_done`.
- `job_busy` out 1: high in every state except IDLE, DONE and ERROR.
- `job_done` out 1: one-cycle pulse on entry to DONE.
- `job_err` out 1: level, high while in ERROR.
- `q_count` out CNT_W: queries completed in the current job.
- `state` out 3: current state encoding, for the status register.

## Operation
State encodings: IDLE=0, CRST=1, LOAD=2, ARM=3, RUN=4, DONE=5, ERROR=6.

- **IDLE/DONE/ERROR**:
  - `core_rs`=0, `core_mode`=0, `core_rst`=0.
  - On `start`:
    - latch the cfg inputs;
    - clear `q_count`, the watchdog counter and `job_err`;
    - go to CRST.
- **CRST**:
  - `core_rst`=1 for exactly RST_CYCLES cycles.
  - Then go to LOAD if `cfg_load_ref`=1, else to ARM.
  - If `cfg_load_ref`=0 and `cfg_num_q`=0, go to DONE instead.
- **LOAD**:
  - `core_mode`=1, `core_rs`=1.
  - When `core_load_done`=1: drop `core_rs`, then go to ARM, or to DONE if the latched num_q is 0.
- **ARM**:
  - `core_mode`=0, `core_rs`=1.
  - Wait for `core_busy`=1, then go to RUN.
- **RUN**:
  - `core_rs`=1.
  - On `core_busy`=0, in the same cycle:
    - `q_count`++;
    - if `q_count`+1 == num_q, go to DONE with `core_rs`=0;
    - otherwise go to ARM.
- **Watchdog**:
  - Counts every cycle in LOAD, ARM and RUN.
  - Clears on each state transition between these states.
  - When it equals the latched timeout (and the timeout ≠ 0), go to ERROR.
  - In ERROR, `core_rst` is pulsed for 1 cycle on entry, and `core_rs`=0.
- **abort**: from any state, go to IDLE next cycle with `core_rs`=0 and `core_rst`=1 for 1 cycle. `q_count` is held. Abort has priority over `start`, watchdog and busy events in the same cycle.
- **Registering**: `core_ref_len` is the latched value, updated only at an accepted `start`. `cfg_*` changes during a job are ignored.
- **Width rules**: `q_count` saturates at all-ones. The watchdog compares equal and never wraps.

## Timing
- **Reset values**: all outputs 0, state=IDLE, `core_ref_len`=0, `q_count`=0.
- **Start to first core action**: `start` sampled at edge N puts CRST active at N+1, so `core_rst` is high on cycles N+1..N+RST_CYCLES. LOAD or ARM begins at N+RST_CYCLES+1.
- **Register timing**: all core-facing outputs are registered, i.e. functions of the current state. No combinational paths from inputs to outputs.
- **Query rate**: each query costs at least 2 scheduler cycles (ARM, then RUN) plus the core's busy time.
- **Simultaneous events**:
  - `core_busy` high already on ARM entry: go to RUN the next cycle.
  - `core_busy` falling in the same cycle as the watchdog limit: completion wins.
- **Ignored requests**: `start` while `job_busy`=1 is ignored, with no state change.
- **DONE**: `job_done` is high exactly 1 cycle. The state remains DONE until `start` or `abort`.

## Test plan
- **Reset**: hold `rst`=1 for 3 cycles with `start`=1 → all outputs 0, state=0.
- **Full job**:
  - Stimulus: `cfg_load_ref`=1, `ref_len`=250, `num_q`=3, RST_CYCLES=4. Core model asserts `load_done` 10 cycles into LOAD and a busy pulse of 20 cycles per query.
  - Required: `core_rst` high 4 cycles; mode=1 during LOAD; 3 ARM/RUN passes; `q_count`=3; `job_done` single pulse; `core_ref_len`=250 throughout.
- **Load-only**: `num_q`=0, `load_ref`=1 → DONE right after `load_done`, `q_count`=0, no ARM state.
- **Watchdog**: `timeout`=50, core never raises busy → ERROR exactly 50 cycles after ARM entry, `job_err`=1, 1-cycle `core_rst`. A following `start` clears `job_err`.
- **Abort**: abort mid-RUN on the 2nd query → IDLE next cycle, `core_rs`=0, `q_count`=1 held.
- **Start while busy**: second `start` pulse during RUN with different cfg → ignored; latched `ref_len`/`num_q` unchanged; job completes normally.

Source files
------------

// File: rtl/dtw_job_sched_if.sv
// Handshake bundle between the register file / core and the DTW job scheduler.
// The slave modport is the scheduler's view; master is the register file and core side.
interface dtw_job_sched_if #(
  parameter int unsigned TIMEOUT_W = 24,
  parameter int unsigned CNT_W     = 16
);
  // Job control and configuration from the register file
  logic                 start;
  logic                 abort;
  logic                 cfg_load_ref;
  logic [31:0]          cfg_ref_len;
  logic [CNT_W-1:0]     cfg_num_q;
  logic [TIMEOUT_W-1:0] cfg_timeout;

  // Core-facing controls and status
  logic                 core_rst;
  logic                 core_rs;
  logic                 core_mode;
  logic [31:0]          core_ref_len;
  logic                 core_busy;
  logic                 core_load_done;

  // Job status back to the register file
  logic                 job_busy;
  logic                 job_done;
  logic                 job_err;
  logic [CNT_W-1:0]     q_count;
  logic [2:0]           state;

  modport slave (
    input  start, abort, cfg_load_ref, cfg_ref_len, cfg_num_q, cfg_timeout,
    input  core_busy, core_load_done,
    output core_rst, core_rs, core_mode, core_ref_len,
    output job_busy, job_done, job_err, q_count, state
  );

  modport master (
    output start, abort, cfg_load_ref, cfg_ref_len, cfg_num_q, cfg_timeout,
    output core_busy, core_load_done,
    input  core_rst, core_rs, core_mode, core_ref_len,
    input  job_busy, job_done, job_err, q_count, state
  );
endinterface

// File: rtl/dtw_job_sched.sv
// DTW job scheduler: resets the core, optionally loads a reference, runs a
// programmed number of query passes, and reports completion or watchdog timeout.
// All core-facing and status outputs are registered from the next state.
module dtw_job_sched #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT_W  = 24,
  parameter int unsigned CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  dtw_job_sched_if.slave bus
);
  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RcW-1:0] RcLast = RcW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCrst  = 3'd1,
    StLoad  = 3'd2,
    StArm   = 3'd3,
    StRun   = 3'd4,
    StDone  = 3'd5,
    StError = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [RcW-1:0]       rc_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [CNT_W-1:0]     num_q_q;
  logic [CNT_W-1:0]     q_cnt_q;
  logic [31:0]          ref_len_q;
  logic                 load_ref_q;
  logic                 core_rst_q, core_rs_q, core_mode_q;
  logic                 job_busy_q, job_done_q, job_err_q;

  logic                 idle_like, accept, wd_expire, q_last, q_step;
  logic [TIMEOUT_W:0]   wd_inc;
  logic [CNT_W:0]       q_inc;

  // Next-state decode; abort beats everything, core progress beats the watchdog
  always_comb begin
    idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
    accept    = bus.start && idle_like && !bus.abort;
    // Count including the current cycle, one bit wider so the compare never wraps
    wd_inc    = {1'b0, wd_q} + 1'b1;
    wd_expire = (timeout_q != '0) && (wd_inc == {1'b0, timeout_q});
    q_inc     = {1'b0, q_cnt_q} + 1'b1;
    q_last    = (q_inc == {1'b0, num_q_q});
    q_step    = (state_q == StRun) && !bus.core_busy && !bus.abort;
    state_d   = state_q;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (bus.start) state_d = StCrst;
        end
        StCrst: begin
          if (rc_q == RcLast) begin
            if (load_ref_q)             state_d = StLoad;
            else if (num_q_q == '0)     state_d = StDone;
            else                        state_d = StArm;
          end
        end
        StLoad: begin
          if (bus.core_load_done)       state_d = (num_q_q == '0) ? StDone : StArm;
          else if (wd_expire)           state_d = StError;
        end
        StArm: begin
          if (bus.core_busy)            state_d = StRun;
          else if (wd_expire)           state_d = StError;
        end
        StRun: begin
          if (!bus.core_busy)           state_d = q_last ? StDone : StArm;
          else if (wd_expire)           state_d = StError;
        end
        default:                        state_d = StIdle;
      endcase
    end
  end

  // State, latched job config, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rc_q        <= '0;
      wd_q        <= '0;
      timeout_q   <= '0;
      num_q_q     <= '0;
      q_cnt_q     <= '0;
      ref_len_q   <= '0;
      load_ref_q  <= 1'b0;
      core_rst_q  <= 1'b0;
      core_rs_q   <= 1'b0;
      core_mode_q <= 1'b0;
      job_busy_q  <= 1'b0;
      job_done_q  <= 1'b0;
      job_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        ref_len_q  <= bus.cfg_ref_len;
        num_q_q    <= bus.cfg_num_q;
        timeout_q  <= bus.cfg_timeout;
        load_ref_q <= bus.cfg_load_ref;
        q_cnt_q    <= '0;
      end else if (q_step && (q_cnt_q != '1)) begin
        q_cnt_q <= q_cnt_q + 1'b1;
      end

      rc_q <= ((state_q == StCrst) && (state_d == StCrst)) ? rc_q + 1'b1 : '0;

      // Watchdog restarts on every state change and saturates instead of wrapping
      if ((state_d != state_q) ||
          !((state_q == StLoad) || (state_q == StArm) || (state_q == StRun))) begin
        wd_q <= '0;
      end else if (wd_q != '1) begin
        wd_q <= wd_q + 1'b1;
      end

      core_rst_q  <= (state_d == StCrst) || bus.abort ||
                     ((state_d == StError) && (state_q != StError));
      core_rs_q   <= (state_d == StLoad) || (state_d == StArm) || (state_d == StRun);
      core_mode_q <= (state_d == StLoad);
      job_busy_q  <= (state_d == StCrst) || (state_d == StLoad) ||
                     (state_d == StArm)  || (state_d == StRun);
      job_done_q  <= (state_d == StDone) && (state_q != StDone);
      job_err_q   <= (state_d == StError);
    end
  end

  assign bus.core_rst     = core_rst_q;
  assign bus.core_rs      = core_rs_q;
  assign bus.core_mode    = core_mode_q;
  assign bus.core_ref_len = ref_len_q;
  assign bus.job_busy     = job_busy_q;
  assign bus.job_done     = job_done_q;
  assign bus.job_err      = job_err_q;
  assign bus.q_count      = q_cnt_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_dtw_job_sched.sv
// Bench for dtw_job_sched: directed job table, abort/reset sequences and random
// jobs checked against a phase-duration model of a whole job.
module tb_dtw_job_sched;
  localparam int unsigned RstCycles = 4;
  localparam int unsigned TimeoutW  = 24;
  localparam int unsigned CntW      = 16;
  localparam int          MaxWait   = 2000;

  typedef struct {
    bit          load_ref;
    logic [31:0] ref_len;
    int          num_q;
    int          timeout;
    int          load_lat;   // LOAD cycles before the core raises load_done
    int          arm_lat;    // ARM cycles before the core raises busy
    int          busy_len;   // cycles busy stays high per query
    int          poke_at;    // observation index of a stray start (0 = none)
    int          exp_cycles; // observations from start until job_busy drops
    bit          exp_err;
    int          exp_q;
    int          exp_mode;   // cycles with core_mode high
  } job_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtw_job_sched_if #(.TIMEOUT_W(TimeoutW), .CNT_W(CntW)) bus ();

  dtw_job_sched #(
    .RST_CYCLES(RstCycles),
    .TIMEOUT_W (TimeoutW),
    .CNT_W     (CntW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int m_load_lat, m_arm_lat, m_busy_len;
  int ld_cnt, run_k;

  task automatic check(input string tag, input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, required %0d", tag, name, act, exp);
    end
  endtask

  // Behavioural core: load_done after m_load_lat LOAD cycles; in query mode a
  // periodic pattern of arm_lat idle, busy_len busy, one completion cycle.
  task automatic core_update();
    int ph;
    if (bus.core_rs && bus.core_mode) begin
      bus.core_load_done = (ld_cnt == m_load_lat);
      ld_cnt++;
    end else begin
      bus.core_load_done = 1'b0;
      ld_cnt = 0;
    end
    if (bus.core_rs && !bus.core_mode) begin
      ph = run_k % (m_arm_lat + m_busy_len + 1);
      bus.core_busy = (ph >= m_arm_lat) && (ph < m_arm_lat + m_busy_len);
      run_k++;
    end else begin
      bus.core_busy = 1'b0;
      run_k = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    core_update();
  endtask

  // A phase that would finish in its need-th cycle is cut to tmo cycles by the watchdog
  function automatic int phase(input int need, input int tmo);
    return (tmo != 0 && tmo < need) ? tmo : need;
  endfunction

  function automatic job_t model(input job_t j);
    job_t r;
    int t, len, q;
    bit err;
    r = j;
    t = int'(RstCycles);
    err = 1'b0;
    q = 0;
    r.exp_mode = 0;
    if (j.load_ref) begin
      len = phase(j.load_lat + 1, j.timeout);
      err = (len != j.load_lat + 1);
      t += len;
      r.exp_mode = len;
    end
    for (int i = 0; i < j.num_q && !err; i++) begin
      len = phase(j.arm_lat + 1, j.timeout);
      err = (len != j.arm_lat + 1);
      t += len;
      if (!err) begin
        len = phase(j.busy_len, j.timeout);
        err = (len != j.busy_len);
        t += len;
        if (!err) q++;
      end
    end
    r.exp_cycles = t + 1;
    r.exp_err    = err;
    r.exp_q      = q;
    return r;
  endfunction

  function automatic job_t mk(input bit lr, input int rl, input int nq, input int tmo,
                              input int ll, input int al, input int bl, input int pk,
                              input int cyc, input bit err, input int q, input int md);
    job_t r;
    r.load_ref = lr;  r.ref_len = rl;  r.num_q = nq;   r.timeout = tmo;
    r.load_lat = ll;  r.arm_lat = al;  r.busy_len = bl; r.poke_at = pk;
    r.exp_cycles = cyc; r.exp_err = err; r.exp_q = q; r.exp_mode = md;
    return r;
  endfunction

  task automatic set_job(input job_t j);
    m_load_lat = j.load_lat;
    m_arm_lat  = j.arm_lat;
    m_busy_len = j.busy_len;
    bus.cfg_load_ref = j.load_ref;
    bus.cfg_ref_len  = j.ref_len;
    bus.cfg_num_q    = CntW'(j.num_q);
    bus.cfg_timeout  = TimeoutW'(j.timeout);
  endtask

  task automatic run_job(input string tag, input job_t j);
    int n, rst_cyc, mode_cyc, ref_bad;
    bit fin;
    n = 0; rst_cyc = 0; mode_cyc = 0; ref_bad = 0; fin = 1'b0;
    set_job(j);
    bus.start = 1'b1;
    for (int c = 0; c < MaxWait && !fin; c++) begin
      tick();
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        check(tag, "crst_entry", int'(bus.state), 1);
        check(tag, "err_cleared", int'(bus.job_err), 0);
        check(tag, "q_cleared", int'(bus.q_count), 0);
      end
      if (j.poke_at != 0 && n == j.poke_at) begin
        bus.start        = 1'b1;
        bus.cfg_load_ref = ~j.load_ref;
        bus.cfg_ref_len  = ~j.ref_len;
        bus.cfg_num_q    = CntW'(j.num_q + 5);
        bus.cfg_timeout  = 3;
      end
      if (j.poke_at != 0 && n == j.poke_at + 1) bus.start = 1'b0;
      if (bus.core_rst) rst_cyc++;
      if (bus.core_mode) mode_cyc++;
      if (bus.core_ref_len != j.ref_len) ref_bad++;
      if (!bus.job_busy) fin = 1'b1;
    end
    bus.start = 1'b0;
    check(tag, "finished", int'(fin), 1);
    check(tag, "cycles", n, j.exp_cycles);
    check(tag, "end_state", int'(bus.state), j.exp_err ? 6 : 5);
    check(tag, "done_pulse", int'(bus.job_done), j.exp_err ? 0 : 1);
    check(tag, "job_err", int'(bus.job_err), int'(j.exp_err));
    check(tag, "q_count", int'(bus.q_count), j.exp_q);
    check(tag, "rst_cycles", rst_cyc, int'(RstCycles) + int'(j.exp_err));
    check(tag, "mode_cycles", mode_cyc, j.exp_mode);
    check(tag, "ref_len_held", ref_bad, 0);
    tick();
    check(tag, "done_drop", int'(bus.job_done), 0);
    check(tag, "core_rst_drop", int'(bus.core_rst), 0);
    check(tag, "state_hold", int'(bus.state), j.exp_err ? 6 : 5);
  endtask

  job_t tbl[9];

  initial begin
    job_t j;
    bit found;
    // load_ref, ref_len, num_q, timeout, load_lat, arm_lat, busy_len, poke_at,
    // exp_cycles, exp_err, exp_q, exp_mode
    tbl[0] = mk(1, 250, 3, 0,  10, 1,   20, 40, 82, 0, 3, 11); // full job + stray start
    tbl[1] = mk(1, 77,  0, 0,  5,  1,   1,  0,  11, 0, 0, 6);  // load only
    tbl[2] = mk(0, 12,  2, 50, 0,  200, 1,  0,  55, 1, 0, 0);  // watchdog in ARM
    tbl[3] = mk(0, 5,   0, 0,  0,  0,   1,  0,  5,  0, 0, 0);  // nothing to do
    tbl[4] = mk(0, 9,   1, 6,  0,  0,   6,  0,  12, 0, 1, 0);  // completion ties timeout
    tbl[5] = mk(0, 9,   1, 5,  0,  0,   6,  0,  11, 1, 0, 0);  // timeout one short in RUN
    tbl[6] = mk(1, 33,  2, 0,  0,  0,   1,  0,  10, 0, 2, 1);  // back-to-back minimal passes
    tbl[7] = mk(1, 44,  1, 10, 10, 2,   3,  0,  15, 1, 0, 10); // watchdog in LOAD
    tbl[8] = mk(1, 44,  1, 11, 10, 2,   3,  0,  22, 0, 1, 11); // LOAD done on last cycle

    m_load_lat = 0; m_arm_lat = 0; m_busy_len = 1; ld_cnt = 0; run_k = 0;
    bus.abort = 1'b0;
    bus.core_busy = 1'b0;
    bus.core_load_done = 1'b0;
    bus.cfg_load_ref = 1'b1;
    bus.cfg_ref_len = 32'hdead_beef;
    bus.cfg_num_q = 7;
    bus.cfg_timeout = 9;

    // Reset held with start high must leave everything cleared
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", "state", int'(bus.state), 0);
    check("reset", "core_rst", int'(bus.core_rst), 0);
    check("reset", "core_rs", int'(bus.core_rs), 0);
    check("reset", "core_mode", int'(bus.core_mode), 0);
    check("reset", "core_ref_len", int'(bus.core_ref_len), 0);
    check("reset", "job_busy", int'(bus.job_busy), 0);
    check("reset", "job_done", int'(bus.job_done), 0);
    check("reset", "job_err", int'(bus.job_err), 0);
    check("reset", "q_count", int'(bus.q_count), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_job($sformatf("tbl%0d", i), tbl[i]);

    // Abort during the second query keeps the completed count
    j = mk(0, 321, 3, 0, 0, 1, 10, 0, 0, 0, 0, 0);
    set_job(j);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < MaxWait && !found; c++) begin
      tick();
      if (bus.q_count == 1 && bus.state == 3'd4) found = 1'b1;
    end
    check("abort", "reached_run2", int'(found), 1);
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort", "state", int'(bus.state), 0);
    check("abort", "core_rs", int'(bus.core_rs), 0);
    check("abort", "core_rst", int'(bus.core_rst), 1);
    check("abort", "q_held", int'(bus.q_count), 1);
    check("abort", "job_busy", int'(bus.job_busy), 0);
    tick();
    check("abort", "core_rst_drop", int'(bus.core_rst), 0);
    check("abort", "idle_hold", int'(bus.state), 0);
    // Abort together with start: abort wins, no job begins
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_start", "state", int'(bus.state), 0);
    check("abort_start", "core_rst", int'(bus.core_rst), 1);
    check("abort_start", "q_held", int'(bus.q_count), 1);
    tick();

    for (int i = 0; i < 40; i++) begin
      j.load_ref = 1'($urandom_range(0, 1));
      j.ref_len  = $urandom;
      j.num_q    = int'($urandom_range(0, 4));
      j.load_lat = int'($urandom_range(0, 12));
      j.arm_lat  = int'($urandom_range(0, 5));
      j.busy_len = int'($urandom_range(1, 8));
      j.timeout  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 14));
      j.poke_at  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 3));
      j = model(j);
      run_job($sformatf("rnd%0d", i), j);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
